ssd_capture: RTL and testbench
==============================

Name: ssd_capture

Overview:
- Sink for a multiplexed two-digit seven-segment display bus, the same bus our BCD counter/display driver produces.
- Samples the shared active-low segment lines and the anode enables, and waits for each digit pattern to be stable.
- Decodes each stable pattern back to BCD and presents the two digits as `first` and `second` with valid, update and error flags.
- Used as a display-bus monitor on the board and as the loopback checker for the display driver.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles that an identical (an, seg) pair must hold before it is captured. Legal range 1..255.
- CNT_W, 8: width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- seg  input  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}.
- an  input  2  anode enables, active-low. an[0] low selects the `first` digit; an[1] low selects the `second` digit.
- err_clr  input  1  single-cycle pulse that clears `err`.
- first  output  4  last captured code for digit 0.
- second  output  4  last captured code for digit 1.
- first_valid  output  1  high once `first` has been captured at least once since reset.
- second_valid  output  1  high once `second` has been captured at least once since reset.
- pair_update  output  1  one-cycle pulse when both digits have been captured since the previous pulse.
- err  output  1  sticky flag: an unrecognised pattern has been captured.

Behaviour:
- Reset: when `reset`=0 at a rising edge, all state clears.
  - first=0, second=0, first_valid=0, second_valid=0, pair_update=0, err=0.
  - Stability counter=0; both internal "captured since last pair_update" flags=0.
  - Reset in the middle of a stability window discards the partial window.
- Input stage:
  - seg and an are registered once.
  - Each cycle the registered pair is compared with the pair registered the previous cycle.
- Legal select: an==2'b10 (digit 0) or an==2'b01 (digit 1).
  - an==2'b11 (blank) or an==2'b00 (both on) is idle.
  - While idle the counter is held at 0 and nothing is captured.
- Stability counter:
  - Legal select and pair unchanged: counter increments, saturating at STABLE_CYCLES.
  - Any change in seg or an: counter restarts at 1, or 0 if the new select is illegal.
- Capture:
  - Exactly one capture when the counter reaches STABLE_CYCLES; no re-capture while the counter stays saturated.
  - A new capture of the same digit needs a change followed by a fresh stable window.
- Latency: a pattern first presented before edge k is captured at edge k+STABLE_CYCLES, and the outputs show it after that edge.
  - With the default 4: pattern presented before edge 1 appears after edge 5.
- Decode, segment value -> code:
  - 7'h40->0, 7'h79->1, 7'h24->2, 7'h30->3, 7'h19->4, 7'h12->5, 7'h02->6, 7'h78->7, 7'h00->8, 7'h10->9.
  - 7'h3F (dash)->4'hE, no error.
  - Any other value->4'hF, and err is set at the same edge.
- Capture updates:
  - The selected digit register is loaded; its valid bit is set and never cleared except by reset.
  - Its "captured since last pulse" flag is set.
- pair_update:
  - Asserted for one cycle on the edge after which both captured flags would be 1; both flags clear at that same edge.
  - If the second capture and the pulse fall on the same edge, the pulse comes from that edge; there is no extra cycle of delay.
- err:
  - Sticky; cleared by err_clr.
  - If err_clr and a new error capture happen on the same edge, err ends at 1 (set wins).
- Digit switching: multiplexing faster than STABLE_CYCLES never captures, so the outputs hold their old values. This is intended filtering.

Decomposition:
- Package ssd_pkg holds:
  - the ten digit segment constants, SEG_DASH, CODE_DASH=4'hE and CODE_BAD=4'hF;
  - an enum for the select decode: SEL_NONE, SEL_FIRST, SEL_SECOND, SEL_BOTH.
- Sub-module ssd_decode: purely combinational, seg[6:0] -> {code[3:0], bad}. It is instantiated once, on the registered segment value.
- Stability counter, capture registers and pair logic stay in ssd_capture.

Test Plan:
- Reset: hold reset=0 for 2 edges, with random seg/an driven -> all outputs 0 after release.
- Digit 0 capture: an=2'b10, seg=7'h30 held for 6 cycles -> first=3 after edge 5; first_valid=1; exactly one capture; pair_update=0.
- Pair update: the case above, then an=2'b01, seg=7'h12 held 4+ cycles -> second=5.
  - pair_update pulses for exactly 1 cycle on the capture edge; first stays 3.
- Glitch rejection: digit-0 pattern held 3 cycles, then an=2'b11 for 1 cycle, repeated 10 times -> no capture.
  - Then hold 4 cycles -> capture occurs.
- Error and dash:
  - seg=7'h7F on digit 1, held -> second=4'hF and err=1.
  - err_clr pulse -> err=0.
  - seg=7'h3F held -> second=4'hE, err stays 0.
  - err_clr on the same edge as a bad capture -> err=1.
- Reset mid-window: stable digit-0 pattern for 2 cycles, reset=0 for 1 edge, then 4 more stable cycles -> capture 4 edges after release, not 2.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants and select decode for the seven-segment display bus monitor.
package ssd_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [3:0] CODE_DASH = 4'hE;
  localparam logic [3:0] CODE_BAD  = 4'hF;

  typedef enum logic [1:0] {SEL_NONE, SEL_FIRST, SEL_SECOND, SEL_BOTH} sel_e;

  // Anodes are active-low: exactly one low bit selects a digit.
  function automatic sel_e sel_decode(input logic [1:0] an);
    case (an)
      2'b10:   sel_decode = SEL_FIRST;
      2'b01:   sel_decode = SEL_SECOND;
      2'b00:   sel_decode = SEL_BOTH;
      default: sel_decode = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ssd_if.sv
// Multiplexed two-digit display bus: shared segment lines plus anode enables.
interface ssd_if;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (output seg, an);
  modport slave  (input  seg, an);
endinterface

// File: rtl/ssd_decode.sv
// Segment pattern back to BCD; unknown patterns map to CODE_BAD and raise bad.
module ssd_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       bad
);

  always_comb begin
    code = CODE_BAD;
    bad  = 1'b1;
    case (seg)
      SEG_0:    begin code = 4'd0;      bad = 1'b0; end
      SEG_1:    begin code = 4'd1;      bad = 1'b0; end
      SEG_2:    begin code = 4'd2;      bad = 1'b0; end
      SEG_3:    begin code = 4'd3;      bad = 1'b0; end
      SEG_4:    begin code = 4'd4;      bad = 1'b0; end
      SEG_5:    begin code = 4'd5;      bad = 1'b0; end
      SEG_6:    begin code = 4'd6;      bad = 1'b0; end
      SEG_7:    begin code = 4'd7;      bad = 1'b0; end
      SEG_8:    begin code = 4'd8;      bad = 1'b0; end
      SEG_9:    begin code = 4'd9;      bad = 1'b0; end
      SEG_DASH: begin code = CODE_DASH; bad = 1'b0; end
      default:  begin code = CODE_BAD;  bad = 1'b1; end
    endcase
  end

endmodule

// File: rtl/ssd_capture.sv
// Display-bus monitor: debounces each (an, seg) pair, decodes it and reports
// both digits with valid, pair-update and sticky error flags.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
)(
  input  logic       clock,
  input  logic       reset,
  ssd_if.slave       bus,
  input  logic       err_clr,
  output logic [3:0] first,
  output logic [3:0] second,
  output logic       first_valid,
  output logic       second_valid,
  output logic       pair_update,
  output logic       err
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [6:0]       seg_r, seg_rr;
  logic [1:0]       an_r, an_rr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             changed, legal, capture;
  sel_e             sel;
  logic [3:0]       code;
  logic             bad;
  logic             got_first, got_second;
  logic             got_first_nxt, got_second_nxt, pair_fire;

  // The sampling pipeline keeps running through reset, so a reset only
  // restarts the window via the counter and the bus is watched right away.
  always_ff @(posedge clock) begin
    seg_r  <= bus.seg;
    an_r   <= bus.an;
    seg_rr <= seg_r;
    an_rr  <= an_r;
  end

  ssd_decode u_dec (
    .seg  (seg_r),
    .code (code),
    .bad  (bad)
  );

  always_comb begin
    sel     = sel_decode(an_r);
    legal   = (sel == SEL_FIRST) || (sel == SEL_SECOND);
    changed = (seg_r != seg_rr) || (an_r != an_rr);
    cnt_nxt = cnt;
    if (!legal)              cnt_nxt = '0;
    else if (changed)        cnt_nxt = CNT_W'(1);
    else if (cnt < STABLE)   cnt_nxt = cnt + CNT_W'(1);
    // Capture on arrival at saturation; a change re-arms even when STABLE is 1.
    capture = legal && (cnt_nxt == STABLE) && (changed || (cnt != STABLE));
  end

  always_comb begin
    got_first_nxt  = got_first  | (capture && (sel == SEL_FIRST));
    got_second_nxt = got_second | (capture && (sel == SEL_SECOND));
    pair_fire      = got_first_nxt && got_second_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt          <= '0;
      first        <= '0;
      second       <= '0;
      first_valid  <= 1'b0;
      second_valid <= 1'b0;
      got_first    <= 1'b0;
      got_second   <= 1'b0;
      pair_update  <= 1'b0;
      err          <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      pair_update <= pair_fire;
      got_first   <= pair_fire ? 1'b0 : got_first_nxt;
      got_second  <= pair_fire ? 1'b0 : got_second_nxt;
      if (capture && (sel == SEL_FIRST)) begin
        first       <= code;
        first_valid <= 1'b1;
      end
      if (capture && (sel == SEL_SECOND)) begin
        second       <= code;
        second_valid <= 1'b1;
      end
      // Set wins over a clear on the same edge.
      if (capture && bad) err <= 1'b1;
      else if (err_clr)   err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture: decode table plus multi-cycle corner cases.
module tb_ssd_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] first, second;
  logic       first_valid, second_valid, pair_update, err;

  ssd_if bus ();

  ssd_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .err_clr      (err_clr),
    .first        (first),
    .second       (second),
    .first_valid  (first_valid),
    .second_valid (second_valid),
    .pair_update  (pair_update),
    .err          (err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] exp_code;
    logic       exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] an, input logic [6:0] seg);
    bus.an  = an;
    bus.seg = seg;
  endtask

  initial begin
    int pulses;
    logic [3:0] got;

    vecs[0]  = '{7'h40, 2'b10, 4'd0, 1'b0};
    vecs[1]  = '{7'h79, 2'b01, 4'd1, 1'b0};
    vecs[2]  = '{7'h24, 2'b10, 4'd2, 1'b0};
    vecs[3]  = '{7'h30, 2'b01, 4'd3, 1'b0};
    vecs[4]  = '{7'h19, 2'b10, 4'd4, 1'b0};
    vecs[5]  = '{7'h12, 2'b01, 4'd5, 1'b0};
    vecs[6]  = '{7'h02, 2'b10, 4'd6, 1'b0};
    vecs[7]  = '{7'h78, 2'b01, 4'd7, 1'b0};
    vecs[8]  = '{7'h00, 2'b10, 4'd8, 1'b0};
    vecs[9]  = '{7'h10, 2'b01, 4'd9, 1'b0};
    vecs[10] = '{7'h3F, 2'b10, 4'hE, 1'b0};
    vecs[11] = '{7'h7F, 2'b01, 4'hF, 1'b1};
    vecs[12] = '{7'h55, 2'b10, 4'hF, 1'b1};

    // Reset with random idle bus traffic.
    reset = 1'b0;
    drive(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 7'($urandom));
    ticks(2);
    check("rst_first", first, 0);
    check("rst_second", second, 0);
    check("rst_first_valid", first_valid, 0);
    check("rst_second_valid", second_valid, 0);
    check("rst_pair_update", pair_update, 0);
    check("rst_err", err, 0);
    reset = 1'b1;

    // Digit 0 capture: visible after the 5th edge, not the 4th.
    drive(2'b10, 7'h30);
    ticks(4);
    check("d0_not_yet_valid", first_valid, 0);
    tick();
    check("d0_first", first, 3);
    check("d0_first_valid", first_valid, 1);
    check("d0_pair_update", pair_update, 0);
    ticks(2);
    check("d0_hold_pair_update", pair_update, 0);

    // Second digit completes the pair; pulse on the capture edge only.
    drive(2'b01, 7'h12);
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      pulses += int'(pair_update);
      if (i == 4) check("pair_early", pair_update, 0);
      if (i == 5) begin
        check("pair_pulse", pair_update, 1);
        check("pair_second", second, 5);
        check("pair_first_kept", first, 3);
      end
      if (i == 6) check("pair_pulse_end", pair_update, 0);
    end
    check("pair_pulse_count", pulses, 1);

    // Glitch rejection: 3-cycle holds broken by a blank never capture.
    for (int r = 0; r < 10; r++) begin
      drive(2'b10, 7'h79);
      ticks(3);
      drive(2'b11, 7'h79);
      tick();
    end
    check("glitch_first_held", first, 3);
    drive(2'b10, 7'h79);
    ticks(4);
    check("glitch_before_window", first, 3);
    tick();
    check("glitch_capture", first, 1);

    // Error, clear, dash, and clear colliding with a bad capture.
    drive(2'b01, 7'h7F);
    ticks(5);
    check("bad_second", second, 4'hF);
    check("bad_err", err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared", err, 0);
    drive(2'b01, 7'h3F);
    ticks(5);
    check("dash_second", second, 4'hE);
    check("dash_no_err", err, 0);
    drive(2'b01, 7'h7E);
    ticks(4);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("set_wins_second", second, 4'hF);
    check("set_wins_err", err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Decode table; alternating anodes guarantee a change before each entry.
    foreach (vecs[i]) begin
      drive(vecs[i].an, vecs[i].seg);
      ticks(5);
      got = (vecs[i].an == 2'b10) ? first : second;
      check($sformatf("dec_code_%0d", i), got, vecs[i].exp_code);
      check($sformatf("dec_err_%0d", i), err, vecs[i].exp_err);
      if (vecs[i].exp_err) begin
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check($sformatf("dec_clr_%0d", i), err, 0);
      end
    end

    // Reset mid-window discards the partial window.
    drive(2'b10, 7'h00);
    ticks(2);
    reset = 1'b0; tick(); reset = 1'b1;
    check("mid_rst_first", first, 0);
    check("mid_rst_valid", first_valid, 0);
    ticks(3);
    check("mid_rst_not_yet", first_valid, 0);
    tick();
    check("mid_rst_capture_valid", first_valid, 1);
    check("mid_rst_capture", first, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
